// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the load/store port and the memory
// port of the arbiter. "slave" is the arbiter's view, "master" the
// environment's view (requesters plus memory).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch port
  logic              ifu_req;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_gnt;
  logic              ifu_rvalid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_err;
  // load/store port
  logic              lsu_req;
  logic              lsu_we;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic              lsu_gnt;
  logic              lsu_rvalid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_err;
  // memory port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req, ifu_addr,
    output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
    output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output ifu_req, ifu_addr,
    input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata,
    input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch, load/store) arbiter in front of a
// 256-word single-cycle memory. One grant per cycle, response one cycle later.
// Default: load/store has priority, a fetch waiting MAX_WAIT cycles overrides.
// Optional macro MEM_ARB_RR_EN: plain round-robin between the two ports.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(1024);

  logic ifu_error;
  logic lsu_error;
  logic ifu_win;
  logic ifu_gnt;
  logic lsu_gnt;

  logic              ifu_rvalid_reg;
  logic [DATA_W-1:0] ifu_rdata_reg;
  logic              ifu_err_reg;
  logic              lsu_rvalid_reg;
  logic [DATA_W-1:0] lsu_rdata_reg;
  logic              lsu_err_reg;

  // An access is bad when misaligned or outside the 1 KiB memory.
  assign ifu_error = (bus.ifu_addr[1:0] != 2'b00) || (bus.ifu_addr >= MEM_LIMIT);
  assign lsu_error = (bus.lsu_addr[1:0] != 2'b00) || (bus.lsu_addr >= MEM_LIMIT);

`ifdef MEM_ARB_RR_EN
  // 0 = load/store was served last, so fetch leads out of reset and the
  // grants alternate fetch, load/store, ... when both ports keep requesting.
  logic last_gnt;

  assign ifu_win = bus.ifu_req && (!bus.lsu_req || !last_gnt);

  // Remember which port was served so the other one is preferred next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b0;
    end else if (ifu_gnt) begin
      last_gnt <= 1'b1;
    end else if (lsu_gnt) begin
      last_gnt <= 1'b0;
    end
  end
`else
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
  logic [3:0] wait_cnt;

  assign ifu_win = bus.ifu_req && (!bus.lsu_req || (wait_cnt >= WAIT_LIMIT));

  // Count cycles the fetch has been kept waiting; saturates at 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (!bus.ifu_req || ifu_gnt) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`endif

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    ifu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (rst_n) begin
      ifu_gnt = ifu_win;
      lsu_gnt = bus.lsu_req && !ifu_win;
    end
  end

  // Capture the response of this cycle's grant for delivery next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifu_rvalid_reg <= 1'b0;
      ifu_rdata_reg  <= '0;
      ifu_err_reg    <= 1'b0;
      lsu_rvalid_reg <= 1'b0;
      lsu_rdata_reg  <= '0;
      lsu_err_reg    <= 1'b0;
    end else begin
      ifu_rvalid_reg <= ifu_gnt;
      lsu_rvalid_reg <= lsu_gnt;
      if (ifu_gnt) begin
        ifu_rdata_reg <= ifu_error ? '0 : bus.mem_rdata;
        ifu_err_reg   <= ifu_error;
      end
      if (lsu_gnt) begin
        lsu_rdata_reg <= (lsu_error || bus.lsu_we) ? '0 : bus.mem_rdata;
        lsu_err_reg   <= lsu_error;
      end
    end
  end

  assign bus.ifu_gnt    = ifu_gnt;
  assign bus.lsu_gnt    = lsu_gnt;
  assign bus.ifu_rvalid = ifu_rvalid_reg;
  assign bus.ifu_rdata  = ifu_rdata_reg;
  assign bus.ifu_err    = ifu_err_reg;
  assign bus.lsu_rvalid = lsu_rvalid_reg;
  assign bus.lsu_rdata  = lsu_rdata_reg;
  assign bus.lsu_err    = lsu_err_reg;

  // Memory port follows the winner; idle cycles present the load/store address.
  assign bus.mem_addr  = ifu_gnt ? bus.ifu_addr : bus.lsu_addr;
  assign bus.mem_we    = lsu_gnt && bus.lsu_we && !lsu_error;
  assign bus.mem_wdata = bus.lsu_wdata;

endmodule
